// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two combinational read ports
// and one synchronous write port. Register x0 is hardwired to zero on the
// read side, and writes addressed to it are dropped.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  addr_x,
  input  logic [4:0]  addr_y,
  output logic [31:0] out_x,
  output logic [31:0] out_y
);

  // Storage array. Benches may preload it hierarchically, so it keeps this plain name.
  logic [31:0] regs [0:31];

  logic        w_writeEn;
  logic [31:0] w_readX;
  logic [31:0] w_readY;

  // A write only lands when it targets a real register. Address 0 is the
  // constant-zero register, so writes to it are discarded here.
  assign w_writeEn = write && (write_addr != 5'd0);

  // Reset clears every entry and takes priority over a write in the same
  // cycle. Otherwise a qualified write updates exactly one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (w_writeEn) begin
      regs[write_addr] <= write_data;
    end
  end

  // Asynchronous reads with no forwarding: a value being written appears
  // only after the edge that stores it. x0 is masked to zero even when the
  // array entry holds preloaded data.
  always_comb begin
    w_readX = regs[addr_x];
    w_readY = regs[addr_y];
    if (addr_x == 5'd0) begin
      w_readX = 32'h0000_0000;
    end
    if (addr_y == 5'd0) begin
      w_readY = 32'h0000_0000;
    end
  end

  assign out_x = w_readX;
  assign out_y = w_readY;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. A reference array tracks the expected
// register contents. Expected read values are queued when addresses are
// driven, then popped and compared once the read ports have settled.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  addr_x;
  logic [4:0]  addr_y;
  logic [31:0] out_x;
  logic [31:0] out_y;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t     scoreboard[$];
  logic [31:0] model [0:31];
  int          checks;
  int          errors;

  reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .write_addr (write_addr),
    .write_data (write_data),
    .addr_x     (addr_x),
    .addr_y     (addr_y),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Value the reference model predicts for a read of address a.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0000_0000 : model[a];
  endfunction

  // Queue the expected values for the addresses currently on the read ports.
  task automatic pushExpect(input string when);
    expect_t e;
    e.tag   = $sformatf("%s x[%0d]", when, addr_x);
    e.value = modelRead(addr_x);
    scoreboard.push_back(e);
    e.tag   = $sformatf("%s y[%0d]", when, addr_y);
    e.value = modelRead(addr_y);
    scoreboard.push_back(e);
  endtask

  // Pop the two queued expectations and compare them with the read ports.
  task automatic popCompare();
    expect_t e;
    if (scoreboard.size() < 2) begin
      checkOutput("scoreboard underflow", 32'(scoreboard.size()), 32'd2);
    end else begin
      e = scoreboard.pop_front();
      checkOutput(e.tag, out_x, e.value);
      e = scoreboard.pop_front();
      checkOutput(e.tag, out_y, e.value);
    end
  endtask

  // Purely combinational read: drive the addresses, wait briefly, then compare.
  task automatic applyRead(input logic [4:0] ax, input logic [4:0] ay);
    addr_x = ax;
    addr_y = ay;
    pushExpect("read");
    #1;
    popCompare();
  endtask

  // One clocked operation. Inputs are driven on the falling edge. The old
  // contents are checked before the rising edge, and the new contents are
  // checked just after it.
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic r);
    @(negedge clk);
    write      = w;
    write_addr = wa;
    write_data = wd;
    rst        = r;
    pushExpect("pre-edge");
    #1;
    popCompare();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
    pushExpect("post-edge");
    popCompare();
    write = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    write      = 1'b0;
    write_addr = 5'd0;
    write_data = 32'h0;
    addr_x     = 5'd0;
    addr_y     = 5'd0;

    // Preload regs[n] = n before any clock edge.
    for (int n = 0; n < 32; n++) begin
      dut.regs[n] = 32'(n);
      model[n]    = 32'(n);
    end

    // With rst high and no edge yet, reads return the preloaded contents, and x0 still reads 0.
    applyRead(5'd3, 5'd0);
    applyRead(5'd31, 5'd30);
    rst = 1'b0;

    // Reads follow the addresses with no clock involvement.
    applyRead(5'd0, 5'd1);
    for (int k = 1; k < 6; k++) applyRead(5'(k), 5'(k + 1));

    // Write to address 1, observed on port Y, with the old value visible before the edge.
    applyRead(5'd1, 5'd1);
    applyStimulus(1'b1, 5'd1, 32'habcd_1234, 1'b0);

    // Writes to x0 are ignored.
    applyRead(5'd0, 5'd2);
    applyStimulus(1'b1, 5'd0, 32'hffff_ffff, 1'b0);
    checkOutput("x0 after write", out_x, 32'h0000_0000);

    // write=0: toggling the data and address across several edges changes nothing.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 5'($urandom_range(1, 31)), $urandom, 1'b0);
    end
    for (int i = 0; i < 32; i++) applyRead(5'(i), 5'(31 - i));

    // Both ports on the same address after writing 32'hdead_beef to register 7.
    applyRead(5'd7, 5'd7);
    applyStimulus(1'b1, 5'd7, 32'hdead_beef, 1'b0);
    checkOutput("same addr x", out_x, 32'hdead_beef);
    checkOutput("same addr y", out_y, 32'hdead_beef);

    // Repeated writes to one address keep the last value written.
    applyRead(5'd9, 5'd10);
    applyStimulus(1'b1, 5'd9, 32'h1111_1111, 1'b0);
    applyStimulus(1'b1, 5'd9, 32'h2222_2222, 1'b0);
    applyStimulus(1'b1, 5'd9, 32'h3333_3333, 1'b0);
    applyStimulus(1'b1, 5'd10, 32'h4444_4444, 1'b0);
    applyRead(5'd9, 5'd10);

    // Reset wins over a simultaneous write, and afterwards everything reads 0.
    applyRead(5'd5, 5'd7);
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 32; i++) applyRead(5'(i), 5'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
